// File: rtl/pool_rd_sched_if.sv
// pool_rd_sched_if
//   Bundles the PE-block read bus and the pooling output stream of the
//   psum read scheduler.
//   master : the scheduler (drives POOLPEB_*, POOL_Val/Dat/PebIdx/Addr/Lst)
//   slave  : the PE blocks plus the pooling unit (drives PEBPOOL_*, POOL_Rdy)
//   PEBPOOL_Req    per-PEB "psums ready" level
//   POOLPEB_Ack    per-PEB one-cycle drain-complete pulse
//   POOLPEB_EnRd   one-hot read enable to the granted PEB
//   POOLPEB_AddrRd psum buffer read address
//   PEBPOOL_Dat    read data, one cycle after EnRd
//   POOL_Val/Rdy   output stream handshake
//   POOL_Dat       psum word
//   POOL_PebIdx    source PEB of the word
//   POOL_Addr      psum address of the word
//   POOL_Lst       word is the last address of its PEB
interface pool_rd_sched_if #(
   parameter int NUMPEB     = 16,
   parameter int LENPSUM    = 16,
   parameter int PSUM_WIDTH = 23
);
   localparam int AW = (LENPSUM > 1) ? $clog2(LENPSUM) : 1;
   localparam int PW = (NUMPEB > 1) ? $clog2(NUMPEB) : 1;

   logic [NUMPEB-1:0]     PEBPOOL_Req;
   logic [NUMPEB-1:0]     POOLPEB_Ack;
   logic [NUMPEB-1:0]     POOLPEB_EnRd;
   logic [AW-1:0]         POOLPEB_AddrRd;
   logic [PSUM_WIDTH-1:0] PEBPOOL_Dat;
   logic                  POOL_Val;
   logic                  POOL_Rdy;
   logic [PSUM_WIDTH-1:0] POOL_Dat;
   logic [PW-1:0]         POOL_PebIdx;
   logic [AW-1:0]         POOL_Addr;
   logic                  POOL_Lst;

   modport master (
      input  PEBPOOL_Req, PEBPOOL_Dat, POOL_Rdy,
      output POOLPEB_Ack, POOLPEB_EnRd, POOLPEB_AddrRd,
             POOL_Val, POOL_Dat, POOL_PebIdx, POOL_Addr, POOL_Lst
   );

   modport slave (
      output PEBPOOL_Req, PEBPOOL_Dat, POOL_Rdy,
      input  POOLPEB_Ack, POOLPEB_EnRd, POOLPEB_AddrRd,
             POOL_Val, POOL_Dat, POOL_PebIdx, POOL_Addr, POOL_Lst
   );
endinterface

// File: rtl/pool_rd_sched.sv
// pool_rd_sched
//   Drains finished psum banks from NUMPEB PE blocks into the pooling stage.
//   Round-robin grants one requesting PEB, sweeps its buffer one address per
//   cycle, and streams the returned words through a 2-entry skid FIFO whose
//   occupancy (plus the word in flight) gates every read issue.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pool_rd_sched_if master modport (PEB read bus + pooling stream)
module pool_rd_sched #(
   parameter int NUMPEB     = 16,
   parameter int LENPSUM    = 16,
   parameter int PSUM_WIDTH = 23
) (
   input logic             clk,
   input logic             rst,
   pool_rd_sched_if.master bus
);
   localparam int AW = (LENPSUM > 1) ? $clog2(LENPSUM) : 1;
   localparam int PW = (NUMPEB > 1) ? $clog2(NUMPEB) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(LENPSUM - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, ACK} state_t;

   state_t                stateCur, stateNxt;
   logic [PW-1:0]         grant, rrPtr, arbIdx;
   logic                  arbHit;
   logic [NUMPEB-1:0]     grantOh;
   logic [AW-1:0]         cnt;
   logic                  inflight;
   logic [AW-1:0]         inflightAddr;
   logic                  issue, pop, push;

   logic [PSUM_WIDTH-1:0] fifoDat  [2];
   logic [PW-1:0]         fifoIdx  [2];
   logic [AW-1:0]         fifoAddr [2];
   logic                  fifoLst  [2];
   logic                  wrPtr, rdPtr;
   logic [1:0]            fifoCnt;

   // Round-robin: first requester at or after rrPtr, wrapping upward.
   always_comb begin : arbiter
      int unsigned cand;
      arbHit = 1'b0;
      arbIdx = '0;
      cand   = 0;
      for (int unsigned i = 0; i < NUMPEB; i++) begin
         cand = 32'(rrPtr) + i;
         if (cand >= 32'(NUMPEB)) cand = cand - 32'(NUMPEB);
         if (!arbHit && bus.PEBPOOL_Req[PW'(cand)]) begin
            arbHit = 1'b1;
            arbIdx = PW'(cand);
         end
      end
   end

   always_comb begin
      grantOh        = '0;
      grantOh[grant] = 1'b1;
   end

   assign pop  = (fifoCnt != 2'd0) && bus.POOL_Rdy;
   assign push = inflight;

   // Credit: buffered + in-flight words, net of this cycle's pop, must leave a
   // free slot; the pop term lets issuing resume in the cycle Rdy returns.
   assign issue = (stateCur == READ) &&
                  (({1'b0, fifoCnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stateCur <= IDLE;
      else     stateCur <= stateNxt;
   end

   always_comb begin
      stateNxt         = stateCur;
      bus.POOLPEB_EnRd = '0;
      bus.POOLPEB_Ack  = '0;
      case (stateCur)
         IDLE: begin
            if (arbHit) stateNxt = READ;
         end
         READ: begin
            if (issue) begin
               bus.POOLPEB_EnRd = grantOh;
               if (cnt == LAST_ADDR) stateNxt = DRAIN;
            end
         end
         DRAIN: begin
            if ((fifoCnt == 2'd0) && !inflight) stateNxt = ACK;
         end
         ACK: begin
            bus.POOLPEB_Ack = grantOh;
            stateNxt        = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   // ---------------- control registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant        <= '0;
         rrPtr        <= '0;
         cnt          <= '0;
         inflight     <= 1'b0;
         inflightAddr <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflightAddr <= cnt;
            cnt          <= cnt + 1'b1;
         end
         if ((stateCur == IDLE) && arbHit) begin
            grant <= arbIdx;
            cnt   <= '0;
         end
         if (stateCur == ACK) begin
            rrPtr <= (grant == PW'(NUMPEB - 1)) ? '0 : grant + 1'b1;
         end
      end
   end

   // ---------------- skid FIFO ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifoDat  <= '{default: '0};
         fifoIdx  <= '{default: '0};
         fifoAddr <= '{default: '0};
         fifoLst  <= '{default: 1'b0};
         wrPtr    <= 1'b0;
         rdPtr    <= 1'b0;
         fifoCnt  <= 2'd0;
      end else begin
         if (push) begin
            fifoDat[wrPtr]  <= bus.PEBPOOL_Dat;
            fifoIdx[wrPtr]  <= grant;
            fifoAddr[wrPtr] <= inflightAddr;
            fifoLst[wrPtr]  <= (inflightAddr == LAST_ADDR);
            wrPtr           <= ~wrPtr;
         end
         if (pop) rdPtr <= ~rdPtr;
         case ({push, pop})
            2'b10:   fifoCnt <= fifoCnt + 2'd1;
            2'b01:   fifoCnt <= fifoCnt - 2'd1;
            default: fifoCnt <= fifoCnt;
         endcase
      end
   end

   assign bus.POOL_Val       = (fifoCnt != 2'd0);
   assign bus.POOL_Dat       = fifoDat[rdPtr];
   assign bus.POOL_PebIdx    = fifoIdx[rdPtr];
   assign bus.POOL_Addr      = fifoAddr[rdPtr];
   assign bus.POOL_Lst       = fifoLst[rdPtr];
   assign bus.POOLPEB_AddrRd = cnt;
endmodule
